pipo_write_arbiter: RTL and testbench

- Shares one N-bit parallel-in/parallel-out register among R requesters.
- Round-robin arbitration grants one write per cycle; each accepted write gets a registered ack pulse.
- A requester may lock the register for back-to-back writes. A lock-duration limit guarantees fairness.
- Sits in front of the register bank as its sole write path. Readers observe q.

---
 rtl/pipo_arb_pkg.sv | 17 +
 rtl/pipo_write_arbiter_rr_pick.sv | 27 ++
 rtl/pipo_write_arbiter.sv | 153 +++++++++++++++
 tb/tb_pipo_write_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipo_arb_pkg.sv
// Shared types and helpers for the PIPO write arbiter.
package pipo_arb_pkg;

  typedef enum logic {IDLE, LOCKED} arb_state_e;

  localparam int MAX_R = 32;

  function automatic int idx_w(input int r);
    return (r > 2) ? $clog2(r) : 1;
  endfunction

  function automatic logic [MAX_R-1:0] onehot(input int unsigned idx, input int unsigned r);
    onehot = '0;
    if (idx < r) onehot = MAX_R'(1) << idx;
  endfunction

endpackage

// File: rtl/pipo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
module rr_pick #(
  parameter int R  = 4,
  parameter int IW = 2
) (
  input  logic [R-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          any_valid
);

  int unsigned idx;

  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < R; k++) begin
      idx = (32'(ptr) + k) % R;
      if (!any_valid && elig[idx]) begin
        grant     = idx[IW-1:0];
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipo_write_arbiter.sv
// Round-robin write arbiter with lock bursts in front of a shared N-bit register.
// Optional parity checking enabled by macro PIPO_ARB_PARITY_EN.
module pipo_write_arbiter
  import pipo_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int R        = 4,
  parameter int LOCK_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [R-1:0]          req,
  input  logic [R-1:0]          lock,
  input  logic [R*N-1:0]        wdata,
  output logic [R-1:0]          ack,
  output logic [N-1:0]          q,
  output logic [idx_w(R)-1:0]   owner,
  output logic                  owner_valid,
  output logic                  busy
`ifdef PIPO_ARB_PARITY_EN
  ,
  input  logic [R-1:0]          wpar,
  output logic                  q_par,
  output logic                  par_err
`endif
);

  localparam int IW = idx_w(R);
  localparam int CW = idx_w(LOCK_MAX);

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    data_q;
  logic [R-1:0]    ack_q, ack_d;
  logic            busy_q, busy_d;

  logic [R-1:0]    elig;
  logic [IW-1:0]   pick_grant;
  logic            pick_any;
  logic            we;
  logic            store;
  logic [IW-1:0]   wsel;
  logic [N-1:0]    wslice;
  logic [MAX_R-1:0] oh;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    if (32'(i) == R - 1) return '0;
    return i + 1'b1;
  endfunction

  // A requester whose ack is showing is masked so a held req is not accepted twice.
  assign elig = req & ~ack_q;

  rr_pick #(.R(R), .IW(IW)) u_pick (
    .elig      (elig),
    .ptr       (ptr_q),
    .grant     (pick_grant),
    .any_valid (pick_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    wsel    = pick_grant;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          we    = 1'b1;
          ptr_d = next_idx(pick_grant);
          if (lock[pick_grant]) begin
            state_d = LOCKED;
            owner_d = pick_grant;
            cnt_d   = '0;
          end
        end
      end
      LOCKED: begin
        wsel  = owner_q;
        cnt_d = cnt_q + 1'b1;
        we    = elig[owner_q];
        if (!lock[owner_q]) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(LOCK_MAX - 1)) begin
          state_d = IDLE;
          ptr_d   = next_idx(owner_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wslice = wdata[wsel*N +: N];
    oh     = onehot(32'(wsel), R);
    ack_d  = we ? oh[R-1:0] : '0;
    busy_d = we;
  end

`ifdef PIPO_ARB_PARITY_EN
  logic par_ok;
  logic q_par_q, par_err_q;

  assign par_ok = (^wslice) == wpar[wsel];
  assign store  = we & par_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_par_q   <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      if (store) q_par_q <= ^wslice;
      if (we && !par_ok) par_err_q <= 1'b1;
    end
  end

  assign q_par   = q_par_q;
  assign par_err = par_err_q;
`else
  assign store = we;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      if (store) data_q <= wslice;
    end
  end

  assign ack         = ack_q;
  assign q           = data_q;
  assign owner       = owner_q;
  assign owner_valid = (state_q == LOCKED);
  assign busy        = busy_q;

endmodule

// File: tb/tb_pipo_write_arbiter.sv
// Self-checking bench: vector table, directed lock/reset sequences, randomized run vs. model.
module tb_pipo_write_arbiter;

  localparam int N  = 4;
  localparam int R  = 4;
  localparam int LM = 4;

  logic        clk;
  logic        in_rst;
  logic [3:0]  in_req, in_lock;
  logic [15:0] in_wd;
  logic [3:0]  ack;
  logic [3:0]  q;
  logic [1:0]  owner;
  logic        ov, busy;

  int passed = 0;
  int total  = 0;

`ifdef PIPO_ARB_PARITY_EN
  logic [3:0] wpar;
  logic       q_par, par_err;
  always_comb for (int i = 0; i < 4; i++) wpar[i] = ^in_wd[i*4 +: 4];
`endif

  pipo_write_arbiter #(.N(N), .R(R), .LOCK_MAX(LM)) dut (
    .clk         (clk),
    .rst         (in_rst),
    .req         (in_req),
    .lock        (in_lock),
    .wdata       (in_wd),
    .ack         (ack),
    .q           (q),
    .owner       (owner),
    .owner_valid (ov),
    .busy        (busy)
`ifdef PIPO_ARB_PARITY_EN
    ,
    .wpar        (wpar),
    .q_par       (q_par),
    .par_err     (par_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: state kept as plain integers.
  bit [3:0] m_ack;
  bit [3:0] m_q;
  bit       m_busy, m_locked;
  int       m_ptr, m_owner, m_cnt;

  function automatic void model_step();
    bit [3:0] el;
    bit [3:0] nack;
    int g;
    nack = '0;
    if (in_rst) begin
      m_q = 0; m_ack = 0; m_busy = 0; m_locked = 0;
      m_ptr = 0; m_owner = 0; m_cnt = 0;
      return;
    end
    el = in_req & ~m_ack;
    if (!m_locked) begin
      g = -1;
      for (int k = 0; k < R; k++)
        if (g < 0 && el[(m_ptr + k) % R]) g = (m_ptr + k) % R;
      if (g >= 0) begin
        m_q = 4'(in_wd >> (g * N));
        nack[g] = 1'b1;
        m_ptr = (g + 1) % R;
        if (in_lock[g]) begin
          m_locked = 1; m_owner = g; m_cnt = 0;
        end
      end
    end else begin
      if (el[m_owner]) begin
        m_q = 4'(in_wd >> (m_owner * N));
        nack[m_owner] = 1'b1;
      end
      if (!in_lock[m_owner]) m_locked = 0;
      else if (m_cnt == LM - 1) begin
        m_locked = 0;
        m_ptr = (m_owner + 1) % R;
      end
      m_cnt++;
    end
    m_ack  = nack;
    m_busy = (nack != 0);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] lk, input logic [15:0] wd);
    in_rst = r; in_req = rq; in_lock = lk; in_wd = wd;
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [15:0] wd;
    logic [3:0]  ack;
    logic [3:0]  q;
    logic        ov;
    logic        busy;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1'b1, 4'hF, 4'h0, 16'hDCBA, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'hF, 4'h0, 16'hDCBA, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 4'hF, 4'h0, 16'hDCBA, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 4'hF, 4'h0, 16'hDCBA, 4'h1, 4'hA, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 4'hE, 4'h0, 16'hDCBA, 4'h2, 4'hB, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 4'hC, 4'h0, 16'hDCBA, 4'h4, 4'hC, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 4'h8, 4'h0, 16'hDCBA, 4'h8, 4'hD, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 4'h0, 4'h0, 16'hDCBA, 4'h0, 4'hD, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 4'h4, 4'h0, 16'h0500, 4'h4, 4'h5, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 4'h4, 4'h0, 16'h0500, 4'h0, 4'h5, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 4'h4, 4'h0, 16'h0500, 4'h4, 4'h5, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 4'h4, 4'h0, 16'h0500, 4'h0, 4'h5, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 4'h0, 4'hF, 16'h0500, 4'h0, 4'h5, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 4'h0, 4'h0, 16'h0500, 4'h0, 4'h5, 1'b0, 1'b0};

    in_rst = 1'b1; in_req = '0; in_lock = '0; in_wd = '0;

    for (int v = 0; v < 14; v++) begin
      drive(tbl[v].rst, tbl[v].req, tbl[v].lock, tbl[v].wd);
      chk($sformatf("vec%0d_ack", v),  16'(ack),  16'(tbl[v].ack));
      chk($sformatf("vec%0d_q", v),    16'(q),    16'(tbl[v].q));
      chk($sformatf("vec%0d_ov", v),   16'(ov),   16'(tbl[v].ov));
      chk($sformatf("vec%0d_busy", v), 16'(busy), 16'(tbl[v].busy));
    end

    // Lock burst: requester 1 locks, requester 3 waits until release.
    drive(1'b1, 4'h0, 4'h0, 16'h0000);
    drive(1'b0, 4'hA, 4'h2, 16'hF010);
    chk("lk0_ack", 16'(ack), 16'h2); chk("lk0_q", 16'(q), 16'h1);
    chk("lk0_ov", 16'(ov), 16'h1);   chk("lk0_owner", 16'(owner), 16'h1);
    drive(1'b0, 4'hA, 4'h2, 16'hF020);
    chk("lk1_ack", 16'(ack), 16'h0); chk("lk1_ov", 16'(ov), 16'h1);
    drive(1'b0, 4'hA, 4'h2, 16'hF020);
    chk("lk2_ack", 16'(ack), 16'h2); chk("lk2_q", 16'(q), 16'h2);
    drive(1'b0, 4'h8, 4'h0, 16'hF000);
    chk("lk3_ack", 16'(ack), 16'h0); chk("lk3_ov", 16'(ov), 16'h0);
    chk("lk3_q", 16'(q), 16'h2);
    drive(1'b0, 4'h8, 4'h0, 16'hF000);
    chk("lk4_ack", 16'(ack), 16'h8); chk("lk4_q", 16'(q), 16'hF);

    // Forced release after LM locked cycles; requester 2 wins next.
    drive(1'b1, 4'h0, 4'h0, 16'h0000);
    drive(1'b0, 4'h5, 4'h1, 16'h0907);
    chk("fr0_ack", 16'(ack), 16'h1); chk("fr0_ov", 16'(ov), 16'h1);
    drive(1'b0, 4'h5, 4'h1, 16'h0907);
    chk("fr1_ack", 16'(ack), 16'h0); chk("fr1_ov", 16'(ov), 16'h1);
    drive(1'b0, 4'h5, 4'h1, 16'h0907);
    chk("fr2_ack", 16'(ack), 16'h1); chk("fr2_ov", 16'(ov), 16'h1);
    drive(1'b0, 4'h5, 4'h1, 16'h0907);
    chk("fr3_ack", 16'(ack), 16'h0); chk("fr3_ov", 16'(ov), 16'h1);
    drive(1'b0, 4'h5, 4'h1, 16'h0907);
    chk("fr4_ack", 16'(ack), 16'h1); chk("fr4_ov", 16'(ov), 16'h0);
    drive(1'b0, 4'h5, 4'h1, 16'h0907);
    chk("fr5_ack", 16'(ack), 16'h4); chk("fr5_q", 16'(q), 16'h9);
    chk("fr5_ov", 16'(ov), 16'h0);

    // Reset while requester 2 owns the lock.
    drive(1'b1, 4'h0, 4'h0, 16'h0000);
    drive(1'b0, 4'h4, 4'h4, 16'h0E00);
    chk("rm0_owner", 16'(owner), 16'h2); chk("rm0_ov", 16'(ov), 16'h1);
    drive(1'b1, 4'h4, 4'h4, 16'h0E00);
    chk("rm1_ov", 16'(ov), 16'h0);   chk("rm1_ack", 16'(ack), 16'h0);
    chk("rm1_q", 16'(q), 16'h0);     chk("rm1_busy", 16'(busy), 16'h0);
    chk("rm1_owner", 16'(owner), 16'h0);
`ifdef PIPO_ARB_PARITY_EN
    chk("rm1_par_err", 16'(par_err), 16'h0);
`endif
    drive(1'b0, 4'h0, 4'h0, 16'h0E00);
    chk("rm2_ack", 16'(ack), 16'h0); chk("rm2_ov", 16'(ov), 16'h0);

    // Randomized traffic following the req/ack protocol.
    drive(1'b1, 4'h0, 4'h0, 16'h0000);
    for (int c = 0; c < 1500; c++) begin
      logic [3:0]  nreq, nlock;
      logic [15:0] nwd;
      logic        nrst;
      nreq = in_req; nlock = in_lock; nwd = in_wd;
      for (int i = 0; i < R; i++) begin
        if (nreq[i] && m_ack[i]) begin
          if ($urandom_range(0, 1) == 0) nreq[i] = 1'b0;
          else nwd[i*4 +: 4] = 4'($urandom);
        end else if (!nreq[i] && $urandom_range(0, 2) == 0) begin
          nreq[i] = 1'b1;
          nwd[i*4 +: 4] = 4'($urandom);
        end
        if ($urandom_range(0, 3) == 0) nlock[i] = ~nlock[i];
      end
      nrst = ($urandom_range(0, 199) == 0);
      if (nrst) nreq = '0;
      drive(nrst, nreq, nlock, nwd);
      chk("rnd_ack", 16'(ack), 16'(m_ack));
      chk("rnd_q", 16'(q), 16'(m_q));
      chk("rnd_ov", 16'(ov), 16'(m_locked));
      chk("rnd_busy", 16'(busy), 16'(m_busy));
      if (m_locked) chk("rnd_owner", 16'(owner), 16'(m_owner));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
